instruction_fetch_unit: RTL and testbench

//  Upstream stage of the single-cycle MIPS CPU controller. Owns the PC and fetches from instruction memory over a req/ready handshake.

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake,
// holds the instruction register and forms the next PC from controller redirects.
// Optional feature: define IFU_PERF_CNT_EN to add retired/redirect counters.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              pcSrc,
  input  logic              jump,
  input  logic              jumpReg,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [31:0]       inst,
  output logic [5:0]        opc,
  output logic [5:0]        func,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              misalign_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       redirect_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_off;
  logic              exec_exit;
  logic              redirect;

  // Next-PC selection; redirect inputs only matter when consumed on EXEC exit.
  always_comb begin
    pc_plus4    = pc_q + PcStep;
    jump_target = pc_plus4;
    // Region bits come from pc_plus4, low 28 bits from the 26-bit index.
    jump_target[27:0] = {inst_q[25:0], 2'b00};
    branch_off  = {{(ADDR_W - 18){inst_q[15]}}, inst_q[15:0], 2'b00};
    redirect    = jump | pcSrc;
    if (jump && jumpReg) begin
      next_pc = {reg_target[ADDR_W-1:2], 2'b00};
    end else if (jump) begin
      next_pc = jump_target;
    end else if (pcSrc) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // FSM next-state: IDLE -> FETCH -> EXEC -> FETCH ...
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    err_d     = err_q;
    exec_exit = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!stall) begin
          exec_exit = 1'b1;
          pc_d      = next_pc;
          state_d   = StFetch;
          if (jump && jumpReg && (reg_target[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] redirect_q;

  // Retired counts every EXEC exit; redirect counts exits that took jump or branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_q  <= '0;
      redirect_q <= '0;
    end else if (exec_exit) begin
      retired_q <= retired_q + 32'd1;
      if (redirect) begin
        redirect_q <= redirect_q + 32'd1;
      end
    end
  end

  assign retired_cnt  = retired_q;
  assign redirect_cnt = redirect_q;
`else
  logic unused_perf;
  assign unused_perf = exec_exit ^ redirect;
`endif

  // Outputs decoded from state and registers only.
  assign imem_req     = (state_q == StFetch);
  assign imem_addr    = pc_q;
  assign inst_valid   = (state_q == StExec);
  assign inst         = inst_q;
  assign opc          = inst_q[31:26];
  assign func         = inst_q[5:0];
  assign pc           = pc_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared each cycle against a behavioural model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall, pcSrc, jump, jumpReg;
  logic [31:0] reg_target;
  logic [31:0] inst;
  logic [5:0]  opc, func;
  logic        inst_valid;
  logic [31:0] pc, pc_plus4;
  logic        misalign_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_cnt, redirect_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .pcSrc       (pcSrc),
    .jump        (jump),
    .jumpReg     (jumpReg),
    .reg_target  (reg_target),
    .inst        (inst),
    .opc         (opc),
    .func        (func),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign_err(misalign_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the unit is in its fetch/execute rhythm, plus architectural state.
  int          m_phase = 0;  // 0 idle, 1 waiting for memory, 2 instruction live
  bit          m_live  = 1'b0;
  logic [31:0] m_pc, m_inst;
  logic        m_err;
  int unsigned m_retired, m_redirects;

  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] iw,
                                                input logic br, input logic j, input logic jr,
                                                input logic [31:0] tgt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = $signed(iw[15:0]);
    if (j && jr) return (tgt / 4) * 4;
    if (j) return (seq & 32'hF000_0000) | (32'(iw[25:0]) * 32'd4);
    if (br) return seq + 32'(off * 4);
    return seq;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_live      <= 1'b1;
      m_phase     <= 0;
      m_pc        <= 32'h0;
      m_inst      <= 32'h0;
      m_err       <= 1'b0;
      m_retired   <= 0;
      m_redirects <= 0;
    end else if (m_live) begin
      if (m_phase == 0) begin
        m_phase <= 1;
      end else if (m_phase == 1) begin
        if (imem_ready) begin
          m_inst  <= imem_rdata;
          m_phase <= 2;
        end
      end else if (!stall) begin
        m_pc      <= model_next_pc(m_pc, m_inst, pcSrc, jump, jumpReg, reg_target);
        m_err     <= m_err | (jump & jumpReg & (reg_target[1:0] != 2'b00));
        m_retired <= m_retired + 1;
        if (jump || pcSrc) m_redirects <= m_redirects + 1;
        m_phase   <= 1;
      end
    end
  end

  // Compare process: every cycle once reset has been seen, mid-cycle.
  always @(negedge clk) begin
    if (m_live) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, (m_phase == 1)});
      check("imem_addr", imem_addr, m_pc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, (m_phase == 2)});
      check("inst", inst, m_inst);
      check("opc", {26'b0, opc}, {26'b0, m_inst[31:26]});
      check("func", {26'b0, func}, {26'b0, m_inst[5:0]});
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
`ifdef IFU_PERF_CNT_EN
      check("retired_cnt", retired_cnt, m_retired);
      check("redirect_cnt", redirect_cnt, m_redirects);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    stall   = 1'b0;
    pcSrc   = 1'b0;
    jump    = 1'b0;
    jumpReg = 1'b0;
  endtask

  // From an EXEC cycle, jr to tgt and land in EXEC holding word.
  task automatic goto_exec(input logic [31:0] tgt, input logic [31:0] word);
    jump       = 1'b1;
    jumpReg    = 1'b1;
    reg_target = tgt;
    tick();
    clr();
    imem_rdata = word;
    imem_ready = 1'b1;
    tick();
  endtask

  logic [31:0] words [3];

  initial begin
    words[0] = 32'h2001_0001;
    words[1] = 32'h8C22_0004;
    words[2] = 32'h0043_1820;
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0; reg_target = 32'h0;
    clr();
    tick();
    tick();

    // Reset state.
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_err", {31'b0, misalign_err}, 32'h0);

    // Zero-wait fetches at 0/4/8.
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("seq_req", {31'b0, imem_req}, 32'h1);
      check("seq_addr", imem_addr, 32'(4 * i));
      check("seq_valid_lo", {31'b0, inst_valid}, 32'h0);
      imem_rdata = words[i];
      tick();
      check("seq_valid_hi", {31'b0, inst_valid}, 32'h1);
      check("seq_inst", inst, words[i]);
      check("seq_pc", pc, 32'(4 * i));
      tick();
    end
    check("seq_opc_w2", {26'b0, opc}, 32'h0);
    check("seq_func_w2", {26'b0, func}, 32'h20);

    // Reset mid-fetch, then wait states at pc 0x4.
    rst = 1'b0;
    tick();
    check("midfetch_req", {31'b0, imem_req}, 32'h0);
    check("midfetch_pc", pc, 32'h0);
    rst = 1'b1;
    tick();
    imem_rdata = words[0];
    tick();
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", imem_addr, 32'h4);
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_inst", inst, words[0]);
      if (i == 2) begin
        imem_ready = 1'b1;
        imem_rdata = words[1];
      end
      tick();
    end
    check("wait_latched", inst, words[1]);
    check("wait_valid", {31'b0, inst_valid}, 32'h1);

    // beq taken / not taken at 0x10.
    goto_exec(32'h10, 32'h1022_FFFE);
    check("beq_pc", pc, 32'h10);
    pcSrc = 1'b1;
    tick();
    clr();
    check("beq_taken", pc, 32'h0C);
    tick();
    goto_exec(32'h10, 32'h1022_FFFE);
    tick();
    check("beq_not_taken", pc, 32'h14);
    tick();

    // j at 0x1000_0020 with index 0x40.
    goto_exec(32'h1000_0020, 32'h0800_0040);
    check("j_link", pc_plus4, 32'h1000_0024);
    jump = 1'b1;
    tick();
    clr();
    check("j_target", pc, 32'h1000_0100);
    tick();

    // jr to a misaligned register value.
    jump = 1'b1; jumpReg = 1'b1; reg_target = 32'h203;
    tick();
    clr();
    check("jr_pc", pc, 32'h200);
    check("jr_err", {31'b0, misalign_err}, 32'h1);
    repeat (4) tick();
    check("jr_err_sticky", {31'b0, misalign_err}, 32'h1);
    check("jr_pc_later", pc, 32'h208);
    imem_rdata = 32'h1234_5678;
    tick();

    // Stall holds pc/inst, then reset during the following fetch.
    stall = 1'b1; pcSrc = 1'b1; jump = 1'b1;
    repeat (4) begin
      tick();
      check("stall_pc", pc, 32'h208);
      check("stall_inst", inst, 32'h1234_5678);
      check("stall_valid", {31'b0, inst_valid}, 32'h1);
    end
    clr();
    tick();
    check("unstall_pc", pc, 32'h20C);
    rst = 1'b0;
    tick();
    check("rst_fetch_pc", pc, 32'h0);
    check("rst_fetch_req", {31'b0, imem_req}, 32'h0);
    check("rst_fetch_err", {31'b0, misalign_err}, 32'h0);
    rst = 1'b1;

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      imem_ready = $urandom_range(0, 1) == 1;
      imem_rdata = $urandom;
      stall      = $urandom_range(0, 99) < 40;
      pcSrc      = $urandom_range(0, 99) < 30;
      jump       = $urandom_range(0, 99) < 20;
      jumpReg    = $urandom_range(0, 1) == 1;
      reg_target = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
